// File: rtl/par_serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial converter.
// Length decode and legality rules live here so every file agrees.
package par_serializer_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // A zero length field encodes a full-width word.
  function automatic int unsigned decode_len(
    input int unsigned mod,
    input int unsigned data_w
  );
    return (mod == 0) ? data_w : mod;
  endfunction

  function automatic logic len_legal(
    input int unsigned len,
    input int unsigned min_len
  );
    return (len >= min_len);
  endfunction

endpackage

// File: rtl/ser_word_buf.sv
// One-entry holding buffer for the serializer: word, length, full flag.
// Push wins over pop so a same-cycle refill never loses a word.
module ser_word_buf #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              full_o,
  output logic [DATA_W-1:0] data_o,
  output logic [LEN_W-1:0]  len_o
);

  logic              full_q;
  logic [DATA_W-1:0] data_q;
  logic [LEN_W-1:0]  len_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      full_q <= 1'b0;
      data_q <= '0;
      len_q  <= '0;
    end else if (push_i) begin
      full_q <= 1'b1;
      data_q <= data_i;
      len_q  <= len_i;
    end else if (pop_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;
  assign len_o  = len_q;

endmodule

// File: rtl/par_serializer.sv
// Parallel word to bit-stream converter with a one-word holding buffer,
// giving gap-free back-to-back words on the serial side.
module par_serializer
  import par_serializer_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MIN_LEN   = 3,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [DATA_W-1:0]         data_i,
  input  logic [$clog2(DATA_W)-1:0] data_mod_i,
  input  logic                      data_val_i,
  output logic                      ready_o,
  output logic                      ser_data_o,
  output logic                      ser_data_val_o,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int unsigned MOD_W = $clog2(DATA_W);
  localparam int unsigned LEN_W = MOD_W + 1;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              err_q;

  logic              buf_full;
  logic [DATA_W-1:0] buf_data;
  logic [LEN_W-1:0]  buf_len;
  logic              push, pop;

  logic [LEN_W-1:0]  in_len;
  logic              in_legal;
  logic              accept;
  logic              acc_ok;
  logic              shifting;
  logic              last;
  logic              free;
  logic              ld_buf;
  logic              ld_in;
  logic              step;

  assign in_len   = LEN_W'(decode_len(32'(data_mod_i), DATA_W));
  assign in_legal = len_legal(32'(in_len), MIN_LEN);

  assign ready_o  = !buf_full;
  assign accept   = data_val_i && ready_o;
  assign acc_ok   = accept && in_legal;

  assign shifting = (state_q == SHIFT);
  assign last     = shifting && (cnt_q == LEN_W'(1));
  assign free     = !shifting || last;

  // The buffered word always goes before a newly offered one.
  assign ld_buf   = free && buf_full;
  assign ld_in    = free && !buf_full && acc_ok;
  assign step     = shifting && !last;

  assign push     = step && acc_ok;
  assign pop      = ld_buf;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      ld_buf: begin
        state_d = SHIFT;
        sreg_d  = buf_data;
        cnt_d   = buf_len;
      end
      ld_in: begin
        state_d = SHIFT;
        sreg_d  = data_i;
        cnt_d   = in_len;
      end
      step: begin
        sreg_d  = MSB_FIRST ? (sreg_q << 1)
                            : (sreg_q >> 1);
        cnt_d   = cnt_q - LEN_W'(1);
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      err_q   <= accept && !in_legal;
    end
  end

  ser_word_buf #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (data_i),
    .len_i   (in_len),
    .full_o  (buf_full),
    .data_o  (buf_data),
    .len_o   (buf_len)
  );

  // Outputs come from registered state only, so reset clears them at once.
  assign ser_data_val_o = shifting;
  assign ser_data_o     = shifting &&
                          (MSB_FIRST ? sreg_q[DATA_W-1]
                                     : sreg_q[0]);
  assign busy_o         = shifting || buf_full;
  assign err_o          = err_q;

endmodule

// File: tb/tb_par_serializer.sv
// Scoreboard bench for par_serializer: MSB-first and LSB-first instances
// share stimulus; a queue model predicts bits, ready, busy and err.
module tb_par_serializer;

  logic        clk;
  logic        rst_n_i;
  logic [15:0] data_i;
  logic [3:0]  data_mod_i;
  logic        data_val_i;

  logic ready_m, ser_m, val_m, busy_m, err_m;
  logic ready_l, ser_l, val_l, busy_l, err_l;

  int checks = 0;
  int errors = 0;

  // Model: bits still to emit per order, and remaining length per word.
  bit bitq_m[$];
  bit bitq_l[$];
  int lenq[$];
  bit err_due = 0;

  par_serializer #(
    .DATA_W(16), .MIN_LEN(3), .MSB_FIRST(1'b1)
  ) dut_m (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .data_i(data_i), .data_mod_i(data_mod_i),
    .data_val_i(data_val_i), .ready_o(ready_m),
    .ser_data_o(ser_m), .ser_data_val_o(val_m),
    .busy_o(busy_m), .err_o(err_m)
  );

  par_serializer #(
    .DATA_W(16), .MIN_LEN(3), .MSB_FIRST(1'b0)
  ) dut_l (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .data_i(data_i), .data_mod_i(data_mod_i),
    .data_val_i(data_val_i), .ready_o(ready_l),
    .ser_data_o(ser_l), .ser_data_val_o(val_l),
    .busy_o(busy_l), .err_o(err_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic act,
                     input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_accept(input logic [15:0] d,
                              input logic [3:0] m);
    int len;
    len = (m == 0) ? 16 : int'(m);
    if (len < 3) begin
      err_due = 1'b1;
    end else begin
      lenq.push_back(len);
      for (int i = 0; i < len; i++) begin
        bitq_m.push_back(d[15-i]);
        bitq_l.push_back(d[i]);
      end
    end
  endtask

  task automatic drive_cycle(input logic v, input logic [15:0] d,
                             input logic [3:0] m, output bit acc);
    @(negedge clk);
    #1;
    data_val_i = v;
    data_i     = d;
    data_mod_i = m;
    #1;
    acc = rst_n_i && v && ready_m;
    if (acc) model_accept(d, m);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++)
      drive_cycle(1'b0, 16'($urandom), 4'($urandom), acc);
  endtask

  task automatic send(input logic [15:0] d, input logic [3:0] m);
    bit done;
    done = 0;
    for (int i = 0; i < 64 && !done; i++)
      drive_cycle(1'b1, d, m, done);
    chk("send_accept", done, 1'b1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ser_m"}, ser_m, 1'b0);
    chk({tag, "_val_m"}, val_m, 1'b0);
    chk({tag, "_busy_m"}, busy_m, 1'b0);
    chk({tag, "_err_m"}, err_m, 1'b0);
    chk({tag, "_ready_m"}, ready_m, 1'b1);
    chk({tag, "_val_l"}, val_l, 1'b0);
    chk({tag, "_busy_l"}, busy_l, 1'b0);
    chk({tag, "_ready_l"}, ready_l, 1'b1);
  endtask

  // Monitor: compare every cycle against the model queues.
  always @(negedge clk) begin
    if (rst_n_i) begin
      chk("ready_m", ready_m, lenq.size() < 2);
      chk("ready_l", ready_l, lenq.size() < 2);
      chk("busy_m", busy_m, lenq.size() > 0);
      chk("busy_l", busy_l, lenq.size() > 0);
      chk("err_m", err_m, err_due);
      chk("err_l", err_l, err_due);
      err_due = 1'b0;
      chk("val_m", val_m, lenq.size() > 0);
      chk("val_l", val_l, lenq.size() > 0);
      if (lenq.size() > 0) begin
        chk("bit_m", ser_m, bitq_m.pop_front());
        chk("bit_l", ser_l, bitq_l.pop_front());
        lenq[0] = lenq[0] - 1;
        if (lenq[0] == 0) void'(lenq.pop_front());
      end else begin
        chk("idle_bit_m", ser_m, 1'b0);
        chk("idle_bit_l", ser_l, 1'b0);
      end
    end
  end

  initial begin
    bit acc;
    rst_n_i    = 1'b0;
    data_val_i = 1'b0;
    data_i     = '0;
    data_mod_i = '0;
    #12;
    chk_reset_outs("por");
    @(negedge clk);
    #1 rst_n_i = 1'b1;
    idle(3);

    send(16'hA5C3, 4'd0);
    idle(20);

    send(16'hFFFF, 4'd4);
    send(16'h0000, 4'd3);
    idle(12);

    send(16'h1234, 4'd2);
    send(16'h00F0, 4'd8);
    idle(12);

    send(16'h8001, 4'd0);
    send(16'h5A5A, 4'd5);
    send(16'h3C3C, 4'd7);
    idle(36);

    send(16'h0001, 4'd4);
    idle(8);

    send(16'hC0DE, 4'd0);
    send(16'hBEEF, 4'd0);
    idle(3);
    @(posedge clk);
    #2 rst_n_i = 1'b0;
    #1;
    chk_reset_outs("async_rst");
    lenq.delete();
    bitq_m.delete();
    bitq_l.delete();
    err_due = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n_i = 1'b1;
    idle(20);

    for (int i = 0; i < 600; i++) begin
      drive_cycle($urandom_range(0, 99) < 70,
                  16'($urandom),
                  4'($urandom_range(0, 15)), acc);
    end
    idle(40);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
